// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus interface.
//
// Bundles the instruction-memory port, the decode-side redirect/hold
// controls, the interrupt handshake and the PC status outputs.
//
//   master : the fetch sequencer (drives addresses, PC, ack, flush)
//   slave  : the environment (memory, decode, interrupt controller)
//
// Signals:
//   imem_addr     instruction memory address
//   imem_rd       instruction memory read enable
//   imem_data     memory read data, one cycle after imem_rd
//   stall         hazard hold request from decode
//   branch_taken  PC redirect request
//   branch_target redirect target
//   int_req       level-sensitive interrupt request
//   int_ack       single-cycle interrupt acknowledge
//   saved_pc      return PC captured on interrupt acceptance
//   pc            current PC
//   fetch_valid   imem_addr is a real instruction fetch
//   flush         one-cycle pulse killing the IF/ID instruction
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_data;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              int_req;
  logic              int_ack;
  logic [ADDR_W-1:0] saved_pc;
  logic [ADDR_W-1:0] pc;
  logic              fetch_valid;
  logic              flush;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  int_req,
    output int_ack,
    output saved_pc,
    output pc,
    output fetch_valid,
    output flush
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data,
    output stall,
    output branch_taken,
    output branch_target,
    output int_req,
    input  int_ack,
    input  saved_pc,
    input  pc,
    input  fetch_valid,
    input  flush
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer.
//
// Generates the instruction-fetch PC. After reset it reads the program
// start address from memory location RESET_VEC, then fetches sequentially,
// honouring decode stalls, branch redirects and interrupts.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  fetch_sequencer_if.master (memory port, decode controls,
//        interrupt handshake, PC status)
//
// Parameters:
//   ADDR_W     PC / address width
//   RESET_VEC  address holding the program start address
//   INT_VEC    first fetch address after an interrupt is accepted
//
// state    | meaning
// ---------+--------------------------------------------------------
// BOOT     | read of RESET_VEC issued
// LOAD     | read data returning, loaded into pc at the edge
// RUN      | normal fetch: branch > interrupt > stall > increment
// INT_SAVE | interrupt acknowledge cycle, pc redirected to INT_VEC
module fetch_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned INT_VEC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] INT_ADDR = ADDR_W'(INT_VEC);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2,
    INT_SAVE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] saved_pc_q;
  logic              flush_q;
  logic              int_ack_q;

  // Interrupts are only taken when decode is not holding the pipe, and a
  // branch in the same cycle always wins (the interrupt simply stays pending).
  logic              int_take;
  assign int_take = bus.int_req && !bus.stall && !bus.branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RST_ADDR;
      saved_pc_q <= '0;
      flush_q    <= 1'b0;
      int_ack_q  <= 1'b0;
    end else begin
      // flush and int_ack are single-cycle pulses by construction.
      flush_q   <= 1'b0;
      int_ack_q <= 1'b0;
      case (state)
        BOOT: begin
          state <= LOAD;
        end
        LOAD: begin
          pc_q  <= bus.imem_data;
          state <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            // Redirect overrides a stall: the held instruction is killed.
            pc_q    <= bus.branch_target;
            flush_q <= 1'b1;
          end else if (int_take) begin
            // The instruction at pc is fetched this cycle and completes,
            // so the return point is the one after it.
            saved_pc_q <= pc_q + PC_INC;
            int_ack_q  <= 1'b1;
            state      <= INT_SAVE;
          end else if (!bus.stall) begin
            pc_q <= pc_q + PC_INC;
          end
        end
        INT_SAVE: begin
          pc_q    <= INT_ADDR;
          flush_q <= 1'b1;
          state   <= RUN;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Memory controls are decoded from state so that a stall suppresses the
  // fetch in the same cycle it is raised.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.imem_rd     = 1'b0;
    bus.fetch_valid = 1'b0;
    case (state)
      BOOT: begin
        bus.imem_addr = RST_ADDR;
        bus.imem_rd   = 1'b1;
      end
      RUN: begin
        bus.imem_rd     = !bus.stall;
        bus.fetch_valid = !bus.stall;
      end
      default: begin
        bus.imem_rd     = 1'b0;
        bus.fetch_valid = 1'b0;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.saved_pc = saved_pc_q;
  assign bus.flush    = flush_q;
  assign bus.int_ack  = int_ack_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: boot, stall/branch, interrupt,
// branch-vs-interrupt priority, 8-bit wrap and reset during INT_SAVE.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(32)) bus ();
  fetch_sequencer_if #(.ADDR_W(8))  bus8 ();

  fetch_sequencer #(.ADDR_W(32), .RESET_VEC(0), .INT_VEC(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_sequencer #(.ADDR_W(8), .RESET_VEC(0), .INT_VEC(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.master)
  );

  // 1-cycle latency memory: location 0 holds the start address 0x10.
  always_ff @(posedge clk) begin
    if (bus.imem_rd)
      bus.imem_data <= (bus.imem_addr == 32'h0) ? 32'h10 : (32'hA500_0000 | bus.imem_addr);
  end

  // The 8-bit instance boots to 0xFD and free-runs.
  assign bus8.imem_data     = 8'hFD;
  assign bus8.stall         = 1'b0;
  assign bus8.branch_taken  = 1'b0;
  assign bus8.branch_target = 8'h00;
  assign bus8.int_req       = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic boot_checks(input string pfx);
    // BOOT cycle
    chk({pfx, "_boot_addr"}, bus.imem_addr, 32'h0);
    chk({pfx, "_boot_rd"}, {31'b0, bus.imem_rd}, 32'h1);
    chk({pfx, "_boot_fv"}, {31'b0, bus.fetch_valid}, 32'h0);
    step();
    // LOAD cycle
    chk({pfx, "_load_rd"}, {31'b0, bus.imem_rd}, 32'h0);
    chk({pfx, "_load_fv"}, {31'b0, bus.fetch_valid}, 32'h0);
    step();
    chk({pfx, "_run_pc"}, bus.pc, 32'h10);
    chk({pfx, "_run_fv"}, {31'b0, bus.fetch_valid}, 32'h1);
    chk({pfx, "_run_addr"}, bus.imem_addr, 32'h10);
    step();
    chk({pfx, "_inc_pc"}, bus.pc, 32'h11);
  endtask

  initial begin
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.int_req       = 1'b0;
    rst               = 1'b1;

    step();
    step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_saved", bus.saved_pc, 32'h0);
    chk("rst_flush", {31'b0, bus.flush}, 32'h0);
    chk("rst_ack", {31'b0, bus.int_ack}, 32'h0);
    chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_rd", {31'b0, bus.imem_rd}, 32'h1);
    chk("rst_addr", bus.imem_addr, 32'h0);

    rst = 1'b0;
    boot_checks("b1");
    chk("w8_pc_fe", {24'b0, bus8.pc}, 32'hFE);

    // Sequential fetch 0x12..0x14; the 8-bit instance wraps FF -> 00.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_pc", bus.pc, 32'h12 + i);
      case (i)
        0: chk("w8_pc_ff", {24'b0, bus8.pc}, 32'hFF);
        1: chk("w8_wrap", {24'b0, bus8.pc}, 32'h00);
        default: chk("w8_pc_01", {24'b0, bus8.pc}, 32'h01);
      endcase
    end

    // Stall three cycles at 0x14.
    bus.stall = 1'b1;
    #1;
    chk("stall_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("stall_rd", {31'b0, bus.imem_rd}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'h14);
    end
    // Branch while still stalled.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    chk("br_pc", bus.pc, 32'h40);
    chk("br_flush", {31'b0, bus.flush}, 32'h1);
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    #1;
    chk("br_fv", {31'b0, bus.fetch_valid}, 32'h1);
    step();
    chk("br_flush_off", {31'b0, bus.flush}, 32'h0);
    chk("br_inc", bus.pc, 32'h41);

    // Interrupt at pc=0x20.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h20;
    step();
    chk("to20_pc", bus.pc, 32'h20);
    bus.branch_taken = 1'b0;
    bus.int_req      = 1'b1;
    step();
    chk("int_ack", {31'b0, bus.int_ack}, 32'h1);
    chk("int_saved", bus.saved_pc, 32'h21);
    chk("int_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("int_rd", {31'b0, bus.imem_rd}, 32'h0);
    bus.int_req = 1'b0;
    step();
    chk("int_vec_pc", bus.pc, 32'h2);
    chk("int_flush", {31'b0, bus.flush}, 32'h1);
    chk("int_ack_off", {31'b0, bus.int_ack}, 32'h0);
    step();
    chk("int_after_pc", bus.pc, 32'h3);
    chk("int_flush_off", {31'b0, bus.flush}, 32'h0);

    // Stall defers an interrupt.
    bus.stall   = 1'b1;
    bus.int_req = 1'b1;
    step();
    chk("defer_ack", {31'b0, bus.int_ack}, 32'h0);
    chk("defer_pc", bus.pc, 32'h3);
    bus.int_req = 1'b0;
    bus.stall   = 1'b0;

    // Branch beats interrupt at pc=0x30.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h30;
    step();
    chk("to30_pc", bus.pc, 32'h30);
    bus.branch_target = 32'h50;
    bus.int_req       = 1'b1;
    step();
    chk("prio_pc", bus.pc, 32'h50);
    chk("prio_no_ack", {31'b0, bus.int_ack}, 32'h0);
    chk("prio_flush", {31'b0, bus.flush}, 32'h1);
    bus.branch_taken = 1'b0;
    step();
    chk("prio_ack", {31'b0, bus.int_ack}, 32'h1);
    chk("prio_saved", bus.saved_pc, 32'h51);
    chk("prio_flush_off", {31'b0, bus.flush}, 32'h0);
    // int_req still high through INT_SAVE: taken again only from RUN.
    step();
    chk("rearm_pc", bus.pc, 32'h2);
    chk("rearm_ack_off", {31'b0, bus.int_ack}, 32'h0);
    step();
    chk("rearm_ack", {31'b0, bus.int_ack}, 32'h1);
    chk("rearm_saved", bus.saved_pc, 32'h3);
    bus.int_req = 1'b0;
    step();
    chk("rearm_pc2", bus.pc, 32'h2);

    // Reset during INT_SAVE.
    bus.int_req = 1'b1;
    step();
    chk("rint_ack", {31'b0, bus.int_ack}, 32'h1);
    bus.int_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rint_ack_drop", {31'b0, bus.int_ack}, 32'h0);
    chk("rint_pc", bus.pc, 32'h0);
    chk("rint_addr", bus.imem_addr, 32'h0);
    chk("rint_rd", {31'b0, bus.imem_rd}, 32'h1);
    chk("rint_saved", bus.saved_pc, 32'h0);
    step();
    rst = 1'b0;
    boot_checks("b2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the PC and all instruction addresses.
REQ-002 The block SHALL have parameter RESET_VEC, default 0, meaning the memory address that holds the program start address.
REQ-003 The block SHALL have parameter INT_VEC, default 2, meaning the address fetched first after an interrupt is accepted.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it SHALL be asynchronous and active-high.
REQ-006 The block SHALL have port imem_addr, output, ADDR_W bits, the instruction memory address.
REQ-007 The block SHALL have port imem_rd, output, 1 bit, the instruction memory read enable.
REQ-008 The block SHALL have port imem_data, input, ADDR_W bits, the memory read data (used only during boot); memory read latency is 1 cycle.
REQ-009 The block SHALL have port stall, input, 1 bit, a hazard hold request from decode.
REQ-010 The block SHALL have ports branch_taken (input, 1 bit) and branch_target (input, ADDR_W bits), a PC redirect request and its target.
REQ-011 The block SHALL have ports int_req (input, 1 bit, level interrupt request) and int_ack (output, 1 bit, single-cycle acknowledge).
REQ-012 The block SHALL have port saved_pc, output, ADDR_W bits, the PC captured when an interrupt is accepted.
REQ-013 The block SHALL have port pc, output, ADDR_W bits, the current PC.
REQ-014 The block SHALL have port fetch_valid, output, 1 bit, asserted when imem_addr is a real fetch.
REQ-015 The block SHALL have port flush, output, 1 bit, a one-cycle pulse that kills the instruction in the IF/ID register.

Function
REQ-016 The block SHALL implement a state machine with states BOOT, LOAD, RUN and INT_SAVE.
REQ-017 BOOT: imem_addr=RESET_VEC, imem_rd=1, fetch_valid=0; the next state SHALL be LOAD unconditionally.
REQ-018 LOAD: imem_rd=0, fetch_valid=0; the block SHALL load imem_data into pc at the clock edge and go to RUN; stall, branch_taken and int_req SHALL be ignored in BOOT and LOAD.
REQ-019 RUN: imem_addr=pc, imem_rd=!stall and fetch_valid=!stall, both combinational.
REQ-020 RUN priority per edge SHALL be: branch_taken > int_req (accepted only when stall=0) > stall > increment.
REQ-021 RUN, branch_taken=1: pc<=branch_target and flush=1 for the next cycle; this SHALL apply even when stall=1.
REQ-022 RUN, int_req=1, stall=0, branch_taken=0: saved_pc<=pc+1 and the next state SHALL be INT_SAVE.
REQ-023 RUN, stall=1 with no branch: pc SHALL hold and int_req SHALL be deferred.
REQ-024 RUN otherwise: pc<=pc+1 modulo 2^ADDR_W, so all-ones wraps to 0 with no flag.
REQ-025 INT_SAVE: fetch_valid=0, imem_rd=0, int_ack=1 for exactly this cycle; at the edge pc<=INT_VEC, flush pulses for the next cycle, and the next state SHALL be RUN.
REQ-026 INT_SAVE: branch_taken, stall and int_req SHALL be ignored; a still-high int_req SHALL be re-accepted only in a later RUN cycle.
REQ-027 flush and int_ack SHALL never be high for more than 1 consecutive cycle per event.

Reset
REQ-028 While rst=1 the block SHALL hold: state=BOOT, pc=RESET_VEC, saved_pc=0, flush=0, int_ack=0, fetch_valid=0, imem_rd=1, imem_addr=RESET_VEC.
REQ-029 Reset asserted in any state, including mid-interrupt, SHALL abort the operation immediately, and the full boot sequence SHALL be repeated after release.

Verification
REQ-030 Boot: release rst with mem[0]=0x10 -> cycle 0 addr=0 rd=1; cycle 1 LOAD; cycle 2 pc=0x10 fetch_valid=1; cycle 3 pc=0x11.
REQ-031 Stall/branch: stall=1 for 3 cycles at pc=0x14 -> pc stays 0x14 and fetch_valid=0; then branch_taken=1, target=0x40, with stall still 1 -> next pc=0x40 and flush=1 for one cycle.
REQ-032 Interrupt: int_req=1 at pc=0x20, stall=0 -> saved_pc=0x21, one INT_SAVE cycle with int_ack=1, then pc=0x2 and flush=1.
REQ-033 Priority: branch_taken and int_req together at pc=0x30, target=0x50 -> pc=0x50, no int_ack; interrupt accepted on the following RUN cycle with saved_pc=0x51.
REQ-034 Wrap: with ADDR_W=8, pc=0xFF and no stall -> next pc=0x00.
REQ-035 Reset mid-operation: assert rst during INT_SAVE -> int_ack drops at once, pc=RESET_VEC; after release the boot sequence restarts.
